light_bar_sequencer: RTL and testbench
======================================

// Module: light_bar_sequencer
// PURPOSE
// Top-level sequencer for the 8-segment green/red light bar. Owns the step timebase
// and runs one of four built-in flash patterns. Switches patterns on a request/ack
// handshake, inserting a blank gap at each switch, and supports pause and disable.
// Sits between the user-control logic (mode buttons, pause switch) and the bar drivers.
// PARAMETERS
// TICK_DIV     12500000  clock cycles per pattern step (>=2)
// BLANK_TICKS  1         steps of all-off output inserted on a mode switch (>=1)
// PORTS
// clock        in   1  system clock, all logic on posedge
// reset        in   1  asynchronous, active-low; clears all state
// enable       in   1  1 = run; 0 = park in IDLE
// pause        in   1  1 = freeze current step and timebase
// mode_sel     in   2  requested pattern: 0 SPLIT, 1 CHASE, 2 BLINK, 3 ALLRED
// mode_load    in   1  request strobe; mode_sel is valid while high
// mode_ack     out  1  one-cycle pulse: request accepted
// active_mode  out  2  pattern currently displayed
// step_tick    out  1  one-cycle pulse on every step advance
// greenLight   out  8  green segment drive, bit 7 = leftmost
// redLight     out  8  red segment drive, bit 7 = leftmost
// BEHAVIOUR
// - Reset values: state IDLE, active_mode 0, step 0, divider 0, mode_ack 0, step_tick 0,
//   greenLight 8'hF0, redLight 8'h0F. All outputs registered.
// - States: IDLE, RUN, HOLD, BLANK.
//   IDLE : enable=1 -> RUN. Divider and step held at 0. Outputs show step 0 of active_mode.
//   RUN  : pause=1 -> HOLD. Accepted load -> BLANK. enable=0 -> IDLE.
//   HOLD : pause=0 -> RUN. Divider count frozen and resumes from the frozen value.
//   BLANK: outputs 8'h00/8'h00 for BLANK_TICKS ticks. Then active_mode <= pending, step 0,
//          -> RUN, or -> HOLD if pause=1 at exit. pause is ignored inside BLANK.
// - Divider: counts 0..TICK_DIV-1 in RUN and BLANK only; wraps to 0.
//   At count==TICK_DIV-1 the next edge raises step_tick for 1 cycle and advances the step.
//   Outputs update on that same edge.
// - Step counter is 3 bits and wraps at the mode length: SPLIT 4, CHASE 8, BLINK 2, ALLRED 1.
//   SPLIT  g/r: F0/0F, 0F/F0, 3C/C3, C3/3C.
//   CHASE  g = 8'h80 >> step, r = ~g.
//   BLINK  even step FF/00, odd step 00/FF.
//   ALLRED 00/FF, constant. step_tick still pulses.
// - Handshake: mode_load=1 in RUN, HOLD or BLANK latches mode_sel into pending and
//   pulses mode_ack on the next edge.
//   A load in HOLD enters BLANK.
//   A load in BLANK overwrites pending and restarts the blank count.
//   mode_load held high accepts once per 2 cycles (ack, then re-sample).
//   A load in IDLE is ignored: no ack.
// - Simultaneous events:
//   load + tick in RUN: load wins, step not advanced, no step_tick.
//   enable=0 has priority over all others.
//   enable=0 in BLANK applies pending immediately, then IDLE.
// - A re-load of the current mode still blanks and restarts at step 0.
// - reset asserted mid-operation: outputs return to reset values asynchronously.
//   After release with enable=1, RUN is entered on the first edge.
// TESTING (TICK_DIV=4, BLANK_TICKS=1)
// 1 reset low, release, enable=1 -> ticks every 4 cycles; g = F0,0F,3C,C3,F0 (wrap).
// 2 mode_sel=1, mode_load 1 cycle -> mode_ack next cycle; 00/00 for 1 tick; then g=80,40..01,80.
// 3 pause=1 mid-step for 10 cycles -> no step_tick, outputs frozen;
//   release -> next tick after the remaining count.
// 4 load aligned with divider wrap -> no step_tick that edge;
//   second load during BLANK -> second mode wins, blank restarts.
// 5 enable=0 in CHASE step 5 -> IDLE, g=80 r=7F, active_mode=1; load in IDLE -> no ack.
// 6 reset pulse mid-BLINK -> immediate F0/0F, active_mode 0, mode_ack 0.

Source files
------------

// File: rtl/light_bar_sequencer_if.sv
// Control/status bundle between the user-control logic and the light bar sequencer.
interface light_bar_sequencer_if;
  logic       enable;
  logic       pause;
  logic [1:0] mode_sel;
  logic       mode_load;
  logic       mode_ack;
  logic [1:0] active_mode;
  logic       step_tick;
  logic [7:0] greenLight;
  logic [7:0] redLight;

  // Controller side: drives requests, observes the bar.
  modport master (
    output enable, pause, mode_sel, mode_load,
    input  mode_ack, active_mode, step_tick, greenLight, redLight
  );

  // Sequencer side.
  modport slave (
    input  enable, pause, mode_sel, mode_load,
    output mode_ack, active_mode, step_tick, greenLight, redLight
  );
endinterface

// File: rtl/light_bar_sequencer.sv
// Light bar sequencer: step timebase, four flash patterns, mode switch handshake with a
// blank gap, pause and enable. All outputs are registered.
module light_bar_sequencer #(
  parameter int unsigned TICK_DIV    = 12500000,
  parameter int unsigned BLANK_TICKS = 1
) (
  input logic                  clock,
  input logic                  reset,
  light_bar_sequencer_if.slave bus
);

  localparam int unsigned DivW   = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int unsigned BlankW = (BLANK_TICKS > 1) ? $clog2(BLANK_TICKS) : 1;
  localparam logic [DivW-1:0]   DivLast   = DivW'(TICK_DIV - 1);
  localparam logic [BlankW-1:0] BlankLast = BlankW'(BLANK_TICKS - 1);

  typedef enum logic [1:0] {StIdle, StRun, StHold, StBlank} state_e;

  state_e              state_q, state_d;
  logic [DivW-1:0]     div_q, div_d;
  logic [BlankW-1:0]   blank_q, blank_d;
  logic [2:0]          step_q, step_d;
  logic [1:0]          mode_q, mode_d;
  logic [1:0]          pend_q, pend_d;
  logic                ack_q, ack_d;
  logic                tick_q, tick_d;
  logic [7:0]          green_q, green_d;
  logic [7:0]          red_q, red_d;
  logic                div_last;
  logic                accept;

  // Segment drive {green, red} for a given pattern and step.
  function automatic logic [15:0] pattern(input logic [1:0] mode, input logic [2:0] step);
    logic [7:0] g;
    logic [7:0] r;
    g = 8'h00;
    r = 8'h00;
    unique case (mode)
      2'd0: begin
        unique case (step[1:0])
          2'd0:    begin g = 8'hF0; r = 8'h0F; end
          2'd1:    begin g = 8'h0F; r = 8'hF0; end
          2'd2:    begin g = 8'h3C; r = 8'hC3; end
          default: begin g = 8'hC3; r = 8'h3C; end
        endcase
      end
      2'd1: begin
        g = 8'h80 >> step;
        r = ~g;
      end
      2'd2: begin
        g = step[0] ? 8'h00 : 8'hFF;
        r = ~g;
      end
      default: begin
        g = 8'h00;
        r = 8'hFF;
      end
    endcase
    return {g, r};
  endfunction

  // Step successor, wrapping at the pattern length (4, 8, 2, 1).
  function automatic logic [2:0] next_step(input logic [1:0] mode, input logic [2:0] step);
    logic [2:0] s;
    unique case (mode)
      2'd0:    s = {1'b0, step[1:0] + 2'd1};
      2'd1:    s = step + 3'd1;
      2'd2:    s = {2'b00, ~step[0]};
      default: s = 3'd0;
    endcase
    return s;
  endfunction

  assign div_last = (div_q == DivLast);
  // The cycle after an ack is not sampled, so a held strobe is accepted every other cycle.
  assign accept   = bus.mode_load & ~ack_q;

  // Next-state: enable has top priority, then an accepted load, then pause/tick.
  always_comb begin
    state_d = state_q;
    div_d   = div_q;
    blank_d = blank_q;
    step_d  = step_q;
    mode_d  = mode_q;
    pend_d  = pend_q;
    ack_d   = 1'b0;
    tick_d  = 1'b0;
    green_d = green_q;
    red_d   = red_q;

    if (!bus.enable) begin
      // Leaving BLANK early still commits the pending mode.
      if (state_q == StBlank) begin
        mode_d = pend_q;
      end
      state_d           = StIdle;
      div_d             = '0;
      step_d            = 3'd0;
      {green_d, red_d}  = pattern((state_q == StBlank) ? pend_q : mode_q, 3'd0);
    end else if (state_q != StIdle && accept) begin
      // Accepted load beats a coincident tick; the blank gap always restarts from zero.
      pend_d  = bus.mode_sel;
      ack_d   = 1'b1;
      state_d = StBlank;
      div_d   = '0;
      blank_d = '0;
      green_d = 8'h00;
      red_d   = 8'h00;
    end else begin
      unique case (state_q)
        StIdle: begin
          state_d = StRun;
        end
        StRun: begin
          if (bus.pause) begin
            state_d = StHold;
          end else if (div_last) begin
            div_d            = '0;
            step_d           = next_step(mode_q, step_q);
            tick_d           = 1'b1;
            {green_d, red_d} = pattern(mode_q, next_step(mode_q, step_q));
          end else begin
            div_d = div_q + DivW'(1);
          end
        end
        StHold: begin
          if (!bus.pause) begin
            state_d = StRun;
          end
        end
        StBlank: begin
          if (div_last) begin
            div_d = '0;
            if (blank_q == BlankLast) begin
              mode_d           = pend_q;
              step_d           = 3'd0;
              state_d          = bus.pause ? StHold : StRun;
              {green_d, red_d} = pattern(pend_q, 3'd0);
            end else begin
              blank_d = blank_q + BlankW'(1);
            end
          end else begin
            div_d = div_q + DivW'(1);
          end
        end
        default: begin
          state_d = StIdle;
        end
      endcase
    end
  end

  // State and output registers with asynchronous active-low clear.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= StIdle;
      div_q   <= '0;
      blank_q <= '0;
      step_q  <= 3'd0;
      mode_q  <= 2'd0;
      pend_q  <= 2'd0;
      ack_q   <= 1'b0;
      tick_q  <= 1'b0;
      green_q <= 8'hF0;
      red_q   <= 8'h0F;
    end else begin
      state_q <= state_d;
      div_q   <= div_d;
      blank_q <= blank_d;
      step_q  <= step_d;
      mode_q  <= mode_d;
      pend_q  <= pend_d;
      ack_q   <= ack_d;
      tick_q  <= tick_d;
      green_q <= green_d;
      red_q   <= red_d;
    end
  end

  assign bus.mode_ack    = ack_q;
  assign bus.active_mode = mode_q;
  assign bus.step_tick   = tick_q;
  assign bus.greenLight  = green_q;
  assign bus.redLight    = red_q;

endmodule

// File: tb/tb_light_bar_sequencer.sv
// Bench for light_bar_sequencer: directed vector table, hand-written corner sequences and
// randomized traffic, all checked against a behavioural model of the light bar.
module tb_light_bar_sequencer;

  localparam int TickDiv    = 4;
  localparam int BlankTicks = 1;

  logic clock;
  logic reset;

  light_bar_sequencer_if bus ();

  light_bar_sequencer #(
    .TICK_DIV   (TickDiv),
    .BLANK_TICKS(BlankTicks)
  ) dut (
    .clock(clock),
    .reset(reset),
    .bus  (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int n_checks = 0;
  int n_fail   = 0;

  // Behavioural model: phase 0 idle, 1 running, 2 held, 3 blank gap.
  int m_phase, m_count, m_step, m_mode, m_pend, m_blanks;
  int m_ack, m_tick, m_g, m_r;
  int split_g[4] = '{8'hF0, 8'h0F, 8'h3C, 8'hC3};
  int mode_len[4] = '{4, 8, 2, 1};

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Every pattern has red as the complement of green.
  task automatic show();
    case (m_mode)
      0:       m_g = split_g[m_step];
      1:       m_g = 128 >> m_step;
      2:       m_g = (m_step % 2 == 0) ? 8'hFF : 8'h00;
      default: m_g = 8'h00;
    endcase
    m_r = m_g ^ 8'hFF;
  endtask

  task automatic model_reset();
    m_phase = 0; m_count = 0; m_step = 0; m_mode = 0; m_pend = 0; m_blanks = 0;
    m_ack = 0; m_tick = 0; m_g = 8'hF0; m_r = 8'h0F;
  endtask

  task automatic model_clock();
    bit acc;
    acc = bus.enable && bus.mode_load && (m_ack == 0) && (m_phase != 0);
    m_ack  = 0;
    m_tick = 0;
    if (!bus.enable) begin
      if (m_phase == 3) m_mode = m_pend;
      m_phase = 0; m_count = 0; m_step = 0;
      show();
    end else if (acc) begin
      m_pend = bus.mode_sel; m_ack = 1; m_phase = 3; m_count = 0; m_blanks = 0;
      m_g = 0; m_r = 0;
    end else begin
      case (m_phase)
        0: m_phase = 1;
        1: begin
          if (bus.pause) m_phase = 2;
          else if (m_count == TickDiv - 1) begin
            m_count = 0;
            m_step  = (m_step + 1) % mode_len[m_mode];
            m_tick  = 1;
            show();
          end else m_count++;
        end
        2: if (!bus.pause) m_phase = 1;
        default: begin
          if (m_count == TickDiv - 1) begin
            m_count = 0;
            m_blanks++;
            if (m_blanks == BlankTicks) begin
              m_mode = m_pend; m_step = 0;
              m_phase = bus.pause ? 2 : 1;
              show();
            end
          end else m_count++;
        end
      endcase
    end
  endtask

  task automatic compare_all();
    check("green", bus.greenLight, m_g);
    check("red", bus.redLight, m_r);
    check("mode_ack", bus.mode_ack, m_ack);
    check("step_tick", bus.step_tick, m_tick);
    check("active_mode", bus.active_mode, m_mode);
  endtask

  // One clock: model follows the edge, outputs sampled on the falling edge.
  task automatic cycle();
    @(posedge clock);
    if (reset) model_clock();
    @(negedge clock);
    compare_all();
  endtask

  task automatic drive(input bit en, input bit pa, input int sel, input bit ld);
    bus.enable    = en;
    bus.pause     = pa;
    bus.mode_sel  = 2'(sel);
    bus.mode_load = ld;
  endtask

  typedef struct {
    bit         en;
    bit         pa;
    int         sel;
    bit         ld;
    int         cycles;
    logic [7:0] g;
    logic [7:0] r;
    logic [1:0] mode;
    bit         ack;
  } vec_t;

  vec_t vecs[$];
  bit   pa_r;

  initial begin
    reset = 1'b0;
    drive(0, 0, 0, 0);
    model_reset();
    @(negedge clock);
    @(negedge clock);
    check("reset_green", bus.greenLight, 8'hF0);
    check("reset_red", bus.redLight, 8'h0F);
    check("reset_mode", bus.active_mode, 0);
    check("reset_ack", bus.mode_ack, 0);
    check("reset_tick", bus.step_tick, 0);

    // Split sequence with wrap, switch to chase, disable at chase step 5, load in idle.
    vecs.push_back(vec_t'{1, 0, 0, 0, 1, 8'hF0, 8'h0F, 2'd0, 0});
    vecs.push_back(vec_t'{1, 0, 0, 0, 4, 8'h0F, 8'hF0, 2'd0, 0});
    vecs.push_back(vec_t'{1, 0, 0, 0, 4, 8'h3C, 8'hC3, 2'd0, 0});
    vecs.push_back(vec_t'{1, 0, 0, 0, 4, 8'hC3, 8'h3C, 2'd0, 0});
    vecs.push_back(vec_t'{1, 0, 0, 0, 4, 8'hF0, 8'h0F, 2'd0, 0});
    vecs.push_back(vec_t'{1, 0, 1, 1, 1, 8'h00, 8'h00, 2'd0, 1});
    vecs.push_back(vec_t'{1, 0, 1, 0, 3, 8'h00, 8'h00, 2'd0, 0});
    vecs.push_back(vec_t'{1, 0, 1, 0, 1, 8'h80, 8'h7F, 2'd1, 0});
    vecs.push_back(vec_t'{1, 0, 1, 0, 4, 8'h40, 8'hBF, 2'd1, 0});
    vecs.push_back(vec_t'{1, 0, 1, 0, 4, 8'h20, 8'hDF, 2'd1, 0});
    vecs.push_back(vec_t'{1, 0, 1, 0, 4, 8'h10, 8'hEF, 2'd1, 0});
    vecs.push_back(vec_t'{1, 0, 1, 0, 4, 8'h08, 8'hF7, 2'd1, 0});
    vecs.push_back(vec_t'{1, 0, 1, 0, 4, 8'h04, 8'hFB, 2'd1, 0});
    vecs.push_back(vec_t'{0, 0, 1, 0, 1, 8'h80, 8'h7F, 2'd1, 0});
    vecs.push_back(vec_t'{0, 0, 2, 1, 1, 8'h80, 8'h7F, 2'd1, 0});
    vecs.push_back(vec_t'{1, 0, 2, 0, 1, 8'h80, 8'h7F, 2'd1, 0});

    drive(1, 0, 0, 0);
    reset = 1'b1;
    foreach (vecs[i]) begin
      drive(vecs[i].en, vecs[i].pa, vecs[i].sel, vecs[i].ld);
      for (int c = 0; c < vecs[i].cycles; c++) cycle();
      check($sformatf("vec%0d_green", i), bus.greenLight, vecs[i].g);
      check($sformatf("vec%0d_red", i), bus.redLight, vecs[i].r);
      check($sformatf("vec%0d_mode", i), bus.active_mode, vecs[i].mode);
      check($sformatf("vec%0d_ack", i), bus.mode_ack, vecs[i].ack);
    end

    // Pause mid-step: frozen for 10 cycles, tick after the remaining two counts.
    drive(1, 0, 0, 0);
    repeat (2) cycle();
    drive(1, 1, 0, 0);
    for (int c = 0; c < 10; c++) begin
      cycle();
      check("hold_tick", bus.step_tick, 0);
      check("hold_green", bus.greenLight, 8'h80);
    end
    drive(1, 0, 0, 0);
    for (int c = 0; c < 2; c++) begin
      cycle();
      check("resume_no_tick", bus.step_tick, 0);
    end
    cycle();
    check("resume_tick", bus.step_tick, 1);
    check("resume_green", bus.greenLight, 8'h40);

    // Load on the divider wrap, then a second load inside the blank gap.
    repeat (3) cycle();
    drive(1, 0, 2, 1);
    cycle();
    check("wrap_load_tick", bus.step_tick, 0);
    check("wrap_load_ack", bus.mode_ack, 1);
    check("wrap_load_green", bus.greenLight, 8'h00);
    drive(1, 0, 2, 0);
    cycle();
    drive(1, 0, 3, 1);
    cycle();
    check("reload_ack", bus.mode_ack, 1);
    drive(1, 0, 3, 0);
    for (int c = 0; c < 3; c++) begin
      cycle();
      check("reblank_green", bus.greenLight, 8'h00);
      check("reblank_red", bus.redLight, 8'h00);
    end
    cycle();
    check("allred_green", bus.greenLight, 8'h00);
    check("allred_red", bus.redLight, 8'hFF);
    check("allred_mode", bus.active_mode, 3);

    // Held strobe: accepted every other cycle.
    drive(1, 0, 0, 1);
    for (int c = 0; c < 4; c++) begin
      cycle();
      check("held_ack", bus.mode_ack, (c % 2 == 0) ? 1 : 0);
    end
    drive(1, 0, 0, 0);
    repeat (3) cycle();
    check("held_exit_green", bus.greenLight, 8'hF0);
    check("held_exit_mode", bus.active_mode, 0);

    // Disable inside the blank gap commits the pending mode.
    drive(1, 0, 2, 1);
    cycle();
    drive(0, 0, 2, 0);
    cycle();
    check("blank_off_mode", bus.active_mode, 2);
    check("blank_off_green", bus.greenLight, 8'hFF);
    check("blank_off_red", bus.redLight, 8'h00);
    drive(1, 0, 2, 0);
    repeat (6) cycle();

    // Asynchronous reset mid-blink.
    #2 reset = 1'b0;
    #1;
    model_reset();
    check("areset_green", bus.greenLight, 8'hF0);
    check("areset_red", bus.redLight, 8'h0F);
    check("areset_mode", bus.active_mode, 0);
    check("areset_ack", bus.mode_ack, 0);
    repeat (2) cycle();
    reset = 1'b1;
    repeat (5) cycle();

    // Randomized traffic against the model, with occasional reset pulses.
    pa_r = 0;
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 9) == 0) pa_r = ~pa_r;
      drive($urandom_range(0, 31) != 0, pa_r, $urandom_range(0, 3), $urandom_range(0, 9) == 0);
      if ($urandom_range(0, 499) == 0) begin
        #2 reset = 1'b0;
        #1;
        model_reset();
        compare_all();
        cycle();
        reset = 1'b1;
      end
      cycle();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
